// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver driven by an external oversample tick, with a valid/ack byte handshake.
// Define UART_RX_MAJORITY_EN to take each bit as the 2-of-3 vote around its mid-bit tick.
module uart_rx_8n1 #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned SAMPLE_RATE = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ack,
    output logic                 framing_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned TickW = (SAMPLE_RATE > 1) ? $clog2(SAMPLE_RATE) : 1;
    localparam int unsigned BitW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TickW-1:0] TickBitEnd = TickW'(SAMPLE_RATE - 1);
    localparam logic [BitW-1:0]  LastBit    = BitW'(DATA_BITS - 1);
`ifdef UART_RX_MAJORITY_EN
    // Decision lands one tick after mid so the vote can include the mid+1 sample.
    localparam logic [TickW-1:0] TickStartEnd = TickW'(SAMPLE_RATE / 2);
`else
    localparam logic [TickW-1:0] TickStartEnd = TickW'(SAMPLE_RATE / 2 - 1);
`endif

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e                 state_q, state_d;
    logic                   rx_meta_q, rx_s_q;
    logic [TickW-1:0]       tick_cnt_q, tick_cnt_d;
    logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   data_valid_q, data_valid_d;
    logic                   framing_error_q, framing_error_d;
    logic                   overrun_q, overrun_d;
    logic                   sample_bit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_serial;
            rx_s_q    <= rx_meta_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // The two previous tick samples; the current rx_s is the third vote.
    logic [1:0] hist_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist_q <= 2'b11;
        end else if (tick) begin
            hist_q <= {hist_q[0], rx_s_q};
        end
    end

    assign sample_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
    assign sample_bit = rx_s_q;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            tick_cnt_q      <= '0;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            data_q          <= '0;
            data_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            tick_cnt_q      <= tick_cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            data_q          <= data_d;
            data_valid_q    <= data_valid_d;
            framing_error_q <= framing_error_d;
            overrun_q       <= overrun_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        tick_cnt_d      = tick_cnt_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        data_d          = data_q;
        data_valid_d    = data_valid_q;
        framing_error_d = 1'b0;
        overrun_d       = overrun_q;

        if (data_ack && data_valid_q) begin
            data_valid_d = 1'b0;
        end

        if (tick) begin
            unique case (state_q)
                StIdle: begin
                    if (!rx_s_q) begin
                        state_d    = StStart;
                        tick_cnt_d = '0;
                    end
                end
                StStart: begin
                    if (tick_cnt_q == TickStartEnd) begin
                        if (sample_bit) begin
                            state_d = StIdle;
                        end else begin
                            state_d    = StData;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (tick_cnt_q == TickBitEnd) begin
                        tick_cnt_d = '0;
                        // Shift in at the MSB end so the first bit ends up in bit 0.
                        shift_d    = {sample_bit, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == LastBit) begin
                            state_d = StStop;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (tick_cnt_q == TickBitEnd) begin
                        tick_cnt_d = '0;
                        if (sample_bit) begin
                            // A load overrides a same-cycle ack and excuses it from overrun.
                            data_d       = shift_q;
                            data_valid_d = 1'b1;
                            if (data_valid_q && !data_ack) begin
                                overrun_d = 1'b1;
                            end
                            state_d = StIdle;
                        end else begin
                            framing_error_d = 1'b1;
                            state_d         = StBreak;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                StBreak: begin
                    if (rx_s_q) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign data          = data_q;
    assign data_valid    = data_valid_q;
    assign framing_error = framing_error_q;
    assign overrun       = overrun_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1: the bench drives tick itself, one line value per tick window.
module tb_uart_rx_8n1;

    localparam int TICK_DIV = 4;
    localparam int SR       = 16;
    localparam int FRAME    = 10 * SR;
`ifdef UART_RX_MAJORITY_EN
    localparam int STOP_ACT = 9 * SR + SR / 2 + 1;
    localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
    localparam int STOP_ACT = 9 * SR + SR / 2;
    localparam logic [7:0] GLITCH_EXP = 8'h08;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       rx_serial = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ack = 1'b0;
    logic       framing_error;
    logic       overrun;
    logic       busy;

    int tests_run = 0;
    int failed = 0;
    int fe_count = 0;

    uart_rx_8n1 #(
        .DATA_BITS  (8),
        .SAMPLE_RATE(SR)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .tick         (tick),
        .rx_serial    (rx_serial),
        .data         (data),
        .data_valid   (data_valid),
        .data_ack     (data_ack),
        .framing_error(framing_error),
        .overrun      (overrun),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (framing_error === 1'b1) fe_count++;
    end

    // Line value is set at the start of the window so it has cleared the synchronizer by the tick.
    task automatic do_tick(input logic v, input logic ack);
        rx_serial = v;
        tick      = 1'b0;
        data_ack  = 1'b0;
        repeat (TICK_DIV - 1) begin
            @(posedge clock);
            #1;
        end
        tick     = 1'b1;
        data_ack = ack;
        @(posedge clock);
        #1;
        tick     = 1'b0;
        data_ack = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int ack_tick,
                              input int glitch_tick, input int nticks);
        logic v;
        int   b;
        for (int i = 0; i < nticks; i++) begin
            b = i / SR;
            if (b == 0) v = 1'b0;
            else if (b == 9) v = stop;
            else v = d[b-1];
            if (i == glitch_tick) v = ~v;
            do_tick(v, i == ack_tick);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        rx_serial = 1'b1;
        tick      = 1'b0;
        data_ack  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        tests_run++;
        if ({data, data_valid, framing_error, overrun, busy} !== 12'h000) begin
            failed++;
            $display("FAIL reset_outputs: got %h want %h",
                     {data, data_valid, framing_error, overrun, busy}, 12'h000);
        end
        do_reset();
        tests_run++;
        if ({data, data_valid, framing_error, overrun, busy} !== 12'h000) begin
            failed++;
            $display("FAIL post_reset_outputs: got %h want %h",
                     {data, data_valid, framing_error, overrun, busy}, 12'h000);
        end
    endtask

    task automatic test_single_frame();
        int fe_base;
        do_reset();
        fe_base = fe_count;
        send_frame(8'hA5, 1'b1, -1, -1, FRAME);
        tests_run++;
        if (data !== 8'hA5) begin
            failed++;
            $display("FAIL a5_data: got %h want %h", data, 8'hA5);
        end
        tests_run++;
        if ({data_valid, framing_error, overrun, busy} !== 4'b1000) begin
            failed++;
            $display("FAIL a5_flags: got %b want %b",
                     {data_valid, framing_error, overrun, busy}, 4'b1000);
        end
        tests_run++;
        if (fe_count - fe_base !== 0) begin
            failed++;
            $display("FAIL a5_fe_pulses: got %0d want 0", fe_count - fe_base);
        end
    endtask

    task automatic test_start_glitch();
        do_reset();
        for (int i = 0; i < 4; i++) do_tick(1'b0, 1'b0);
        tests_run++;
        if (busy !== 1'b1) begin
            failed++;
            $display("FAIL glitch_busy_during: got %b want 1", busy);
        end
        for (int i = 0; i < 8; i++) do_tick(1'b1, 1'b0);
        tests_run++;
        if ({busy, data_valid} !== 2'b00) begin
            failed++;
            $display("FAIL glitch_idle: got %b want %b", {busy, data_valid}, 2'b00);
        end
    endtask

    task automatic test_framing_error();
        int fe_base;
        do_reset();
        fe_base = fe_count;
        send_frame(8'h3C, 1'b0, -1, -1, FRAME);
        for (int i = 0; i < 40; i++) do_tick(1'b0, 1'b0);
        tests_run++;
        if (fe_count - fe_base !== 1) begin
            failed++;
            $display("FAIL fe_pulse_count: got %0d want 1", fe_count - fe_base);
        end
        tests_run++;
        if ({busy, data_valid, framing_error} !== 3'b100) begin
            failed++;
            $display("FAIL fe_break_hold: got %b want %b",
                     {busy, data_valid, framing_error}, 3'b100);
        end
        tests_run++;
        if (data !== 8'h00) begin
            failed++;
            $display("FAIL fe_data_unchanged: got %h want %h", data, 8'h00);
        end
        for (int i = 0; i < 2; i++) do_tick(1'b1, 1'b0);
        tests_run++;
        if ({busy, data_valid} !== 2'b00) begin
            failed++;
            $display("FAIL fe_release: got %b want %b", {busy, data_valid}, 2'b00);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        send_frame(8'h11, 1'b1, -1, -1, FRAME);
        send_frame(8'h22, 1'b1, -1, -1, FRAME);
        tests_run++;
        if (data !== 8'h22) begin
            failed++;
            $display("FAIL ovr_data: got %h want %h", data, 8'h22);
        end
        tests_run++;
        if ({data_valid, overrun} !== 2'b11) begin
            failed++;
            $display("FAIL ovr_flags: got %b want %b", {data_valid, overrun}, 2'b11);
        end
        data_ack = 1'b1;
        @(posedge clock);
        #1;
        data_ack = 1'b0;
        tests_run++;
        if ({data_valid, overrun} !== 2'b01) begin
            failed++;
            $display("FAIL ovr_after_ack: got %b want %b", {data_valid, overrun}, 2'b01);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_frame(8'h7E, 1'b1, -1, -1, FRAME);
        tests_run++;
        if ({data, data_valid} !== {8'h7E, 1'b1}) begin
            failed++;
            $display("FAIL b2b_first: got %h want %h", {data, data_valid}, {8'h7E, 1'b1});
        end
        send_frame(8'h81, 1'b1, STOP_ACT, -1, FRAME);
        tests_run++;
        if (data !== 8'h81) begin
            failed++;
            $display("FAIL b2b_data: got %h want %h", data, 8'h81);
        end
        tests_run++;
        if ({data_valid, overrun} !== 2'b10) begin
            failed++;
            $display("FAIL b2b_load_wins: got %b want %b", {data_valid, overrun}, 2'b10);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        send_frame(8'hC3, 1'b1, -1, -1, FRAME);
        send_frame(8'hC3, 1'b1, -1, -1, FRAME);
        send_frame(8'hFF, 1'b1, -1, -1, 5 * SR + SR / 2);
        tests_run++;
        if ({busy, overrun, data_valid} !== 3'b111) begin
            failed++;
            $display("FAIL mid_pre_reset: got %b want %b", {busy, overrun, data_valid}, 3'b111);
        end
        #2;
        reset     = 1'b1;
        rx_serial = 1'b1;
        #1;
        tests_run++;
        if ({data, data_valid, framing_error, overrun, busy} !== 12'h000) begin
            failed++;
            $display("FAIL mid_async_reset: got %h want %h",
                     {data, data_valid, framing_error, overrun, busy}, 12'h000);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        send_frame(8'h5A, 1'b1, -1, -1, FRAME);
        tests_run++;
        if ({data, data_valid, overrun, busy} !== {8'h5A, 3'b100}) begin
            failed++;
            $display("FAIL mid_next_frame: got %h want %h",
                     {data, data_valid, overrun, busy}, {8'h5A, 3'b100});
        end
    endtask

    task automatic test_data_glitch();
        do_reset();
        send_frame(8'h00, 1'b1, -1, 4 * SR + SR / 2, FRAME);
        tests_run++;
        if ({data, data_valid} !== {GLITCH_EXP, 1'b1}) begin
            failed++;
            $display("FAIL bit3_glitch: got %h want %h", {data, data_valid}, {GLITCH_EXP, 1'b1});
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_start_glitch();
        test_framing_error();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        test_data_glitch();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
